// File: rtl/mac_layer_sequencer.sv
// Sequential evaluator for an M-layer, N-neuron fully connected network.
// A single MAC datapath walks every neuron, reading its weights from an external synchronous RAM.
module mac_layer_sequencer #(
    parameter int INT_PART   = 3,
    parameter int FRACT_PART = 5,
    parameter int N          = 4,
    parameter int M          = 3,
    parameter int RELU       = 1,
    localparam int W         = INT_PART + FRACT_PART,
    localparam int ADDR_W    = (M * N * N > 1) ? $clog2(M * N * N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N*W-1:0]        in_values,
    input  logic signed [W-1:0]   bias,
    output logic [ADDR_W-1:0]     w_addr,
    output logic                  w_en,
    input  logic signed [W-1:0]   w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [N*W-1:0]        out_values
);

    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int LAYER_W = (M > 1) ? $clog2(M) : 1;
    localparam int ACC_W   = 2 * W + $clog2(N) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (W - 1)));

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WB, S_DONE} state_t;

    state_t                   state_reg, state_next;
    logic [LAYER_W-1:0]       layer_reg;
    logic [IDX_W-1:0]         neuron_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [W-1:0]      act_reg [N];
    logic signed [W-1:0]      nxt_reg [N];
    logic signed [W-1:0]      out_reg [N];
    logic                     out_valid_reg;
    logic [ADDR_W-1:0]        w_addr_hold_reg;

    logic                     last_idx, last_neuron, last_layer;
    logic [ADDR_W-1:0]        addr_cur, addr_inc;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext, bias_ext, shifted;
    logic signed [W-1:0]      r;

    assign last_idx    = (idx_reg == IDX_W'(N - 1));
    assign last_neuron = (neuron_reg == IDX_W'(N - 1));
    assign last_layer  = (layer_reg == LAYER_W'(M - 1));

    assign addr_cur = ADDR_W'(int'(layer_reg) * N * N + int'(neuron_reg) * N + int'(idx_reg));
    assign addr_inc = ADDR_W'(int'(layer_reg) * N * N + int'(neuron_reg) * N + int'(idx_reg) + 1);

    assign prod     = act_reg[idx_reg] * w_data;
    assign prod_ext = {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
    assign bias_ext = {{(ACC_W - W){bias[W-1]}}, bias};
    assign shifted  = acc_reg >>> FRACT_PART;

    // Saturate the rescaled accumulator to the W-bit range, then optional ReLU.
    always_comb begin
        if (shifted > SAT_MAX) begin
            r = SAT_MAX[W-1:0];
        end else if (shifted < SAT_MIN) begin
            r = SAT_MIN[W-1:0];
        end else begin
            r = shifted[W-1:0];
        end
        if (RELU != 0 && r[W-1]) begin
            r = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: state_next = S_MAC;
            S_MAC:   if (last_idx) state_next = S_WB;
            S_WB:    state_next = (last_neuron && last_layer) ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_en   = 1'b0;
        w_addr = w_addr_hold_reg;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                busy   = 1'b1;
                w_en   = 1'b1;
                w_addr = addr_cur;
            end
            S_MAC: begin
                busy = 1'b1;
                if (!last_idx) begin
                    w_en   = 1'b1;
                    w_addr = addr_inc;
                end
            end
            S_WB: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_reg       <= '0;
            neuron_reg      <= '0;
            idx_reg         <= '0;
            acc_reg         <= '0;
            out_valid_reg   <= 1'b0;
            w_addr_hold_reg <= '0;
        end else begin
            w_addr_hold_reg <= w_addr;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        layer_reg     <= '0;
                        neuron_reg    <= '0;
                        idx_reg       <= '0;
                        out_valid_reg <= 1'b0;
                    end
                end
                S_FETCH: acc_reg <= bias_ext <<< FRACT_PART;
                S_MAC: begin
                    acc_reg <= acc_reg + prod_ext;
                    if (!last_idx) begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                S_WB: begin
                    idx_reg <= '0;
                    if (!last_neuron) begin
                        neuron_reg <= neuron_reg + IDX_W'(1);
                    end else begin
                        neuron_reg <= '0;
                        if (!last_layer) begin
                            layer_reg <= layer_reg + LAYER_W'(1);
                        end
                    end
                end
                S_DONE: out_valid_reg <= 1'b1;
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;

    // Ping-pong: nxt collects a layer's results; act is swapped in at the last neuron's write-back.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    act_reg[gi] <= '0;
                    nxt_reg[gi] <= '0;
                    out_reg[gi] <= '0;
                end else begin
                    if (state_reg == S_WB && neuron_reg == IDX_W'(gi)) begin
                        nxt_reg[gi] <= r;
                    end
                    if (state_reg == S_IDLE && start) begin
                        act_reg[gi] <= in_values[gi*W +: W];
                    end else if (state_reg == S_WB && last_neuron) begin
                        act_reg[gi] <= (gi == N - 1) ? r : nxt_reg[gi];
                    end
                    if (state_reg == S_DONE) begin
                        out_reg[gi] <= act_reg[gi];
                    end
                end
            end
            assign out_values[gi*W +: W] = out_reg[gi];
        end
    endgenerate

endmodule
